// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - RV32I OP/OP-IMM decode and ALU sequencing with writeback handshake
module alu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            alu_enable_n,
  output logic [2:0]      alu_opcode,
  output logic            alu_signal,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_illegal,
  output logic [31:0]     retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  state_t          state_q, state_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      op_q, op_d;
  logic            sig_q, sig_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [31:0]     retired_q, retired_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            dec_legal;
  logic            dec_sig;
  logic [XLEN-1:0] dec_b;
  logic            unused_rs_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register specifiers arrive pre-read as rs1_data/rs2_data, so the index fields are not needed.
  assign unused_rs_fields = ^instr[19:15];

  // Decode the offered instruction into ALU controls and a legality flag.
  always_comb begin
    dec_legal = 1'b0;
    dec_sig   = 1'b0;
    dec_b     = '0;
    if (opcode == OPC_OP) begin
      dec_b = rs2_data;
      if (funct7 == F7_ZERO) begin
        dec_legal = 1'b1;
      end else if (funct7 == F7_ALT && (funct3 == 3'd0 || funct3 == 3'd5)) begin
        dec_legal = 1'b1;
        dec_sig   = 1'b1;
      end
    end else if (opcode == OPC_OP_IMM) begin
      dec_b = {{(XLEN-12){instr[31]}}, instr[31:20]};
      case (funct3)
        3'd1: dec_legal = (funct7 == F7_ZERO);
        3'd5: begin
          dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          dec_sig   = instr[30];
        end
        default: dec_legal = 1'b1;
      endcase
    end
  end

  // Next-state and latched-field update for the IDLE/EXEC/WB sequence.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    op_d      = op_q;
    sig_d     = sig_q;
    a_d       = a_q;
    b_d       = b_q;
    illegal_d = illegal_q;
    wb_data_d = wb_data_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          rd_d      = instr[11:7];
          illegal_d = ~dec_legal;
          op_d      = dec_legal ? funct3 : 3'd0;
          sig_d     = dec_legal & dec_sig;
          a_d       = dec_legal ? rs1_data : '0;
          b_d       = dec_legal ? dec_b : '0;
          wb_data_d = '0;
          state_d   = dec_legal ? EXEC : WB;
        end
      end
      EXEC: begin
        // x0 writes are forced to zero so downstream never sees a nonzero x0 value.
        wb_data_d = (rd_q == 5'd0) ? '0 : alu_result;
        state_d   = WB;
      end
      WB: begin
        if (wb_ready) begin
          if (!illegal_q) begin
            retired_d = retired_q + 32'd1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-field registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      op_q      <= '0;
      sig_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      illegal_q <= 1'b0;
      wb_data_q <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      op_q      <= op_d;
      sig_q     <= sig_d;
      a_q       <= a_d;
      b_q       <= b_d;
      illegal_q <= illegal_d;
      wb_data_q <= wb_data_d;
      retired_q <= retired_d;
    end
  end

  // ALU controls are driven only while executing; otherwise they are held at zero.
  always_comb begin
    instr_ready  = (state_q == IDLE);
    alu_enable_n = 1'b1;
    alu_opcode   = 3'd0;
    alu_signal   = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    if (state_q == EXEC) begin
      alu_enable_n = 1'b0;
      alu_opcode   = op_q;
      alu_signal   = sig_q;
      alu_a        = a_q;
      alu_b        = b_q;
    end
    wb_valid   = (state_q == WB);
    wb_rd      = rd_q;
    wb_data    = wb_data_q;
    wb_illegal = illegal_q;
    retired    = retired_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        alu_enable_n;
  logic [2:0]  alu_opcode;
  logic        alu_signal;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_illegal;
  logic [31:0] retired;

  int checks;
  int failures;

  alu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_enable_n(alu_enable_n), .alu_opcode(alu_opcode), .alu_signal(alu_signal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_illegal(wb_illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; drives garbage when disabled so a missed enable shows up in wb_data.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    if (!alu_enable_n) begin
      case (alu_opcode)
        3'd0: alu_result = alu_signal ? (alu_a - alu_b) : (alu_a + alu_b);
        3'd1: alu_result = alu_a << alu_b[4:0];
        3'd2: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
        3'd3: alu_result = {31'd0, alu_a < alu_b};
        3'd4: alu_result = alu_a ^ alu_b;
        3'd5: alu_result = alu_signal ? 32'($signed(alu_a) >>> alu_b[4:0]) : (alu_a >> alu_b[4:0]);
        3'd6: alu_result = alu_a | alu_b;
        default: alu_result = alu_a & alu_b;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction at a negedge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instr       = i;
    rs1_data    = a;
    rs2_data    = b;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    rs1_data    = 32'd0;
    rs2_data    = 32'd0;
    wb_ready    = 1'b1;
    #12;
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_alu_enable_n", 32'(alu_enable_n), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x3, x1, x2
    issue(32'h002081B3, 32'd5, 32'd7);
    chk("add_exec_en_n", 32'(alu_enable_n), 32'd0);
    chk("add_exec_op", 32'(alu_opcode), 32'd0);
    chk("add_exec_sig", 32'(alu_signal), 32'd0);
    chk("add_exec_a", alu_a, 32'd5);
    chk("add_exec_b", alu_b, 32'd7);
    chk("add_exec_ready", 32'(instr_ready), 32'd0);
    chk("add_exec_wbv", 32'(wb_valid), 32'd0);
    step();
    chk("add_wb_valid", 32'(wb_valid), 32'd1);
    chk("add_wb_rd", 32'(wb_rd), 32'd3);
    chk("add_wb_data", wb_data, 32'd12);
    chk("add_wb_illegal", 32'(wb_illegal), 32'd0);
    chk("add_wb_en_n", 32'(alu_enable_n), 32'd1);
    step();
    chk("add_retired", retired, 32'd1);
    chk("add_idle_ready", 32'(instr_ready), 32'd1);

    // SUB x3, x1, x2
    issue(32'h402081B3, 32'd5, 32'd7);
    chk("sub_exec_sig", 32'(alu_signal), 32'd1);
    step();
    chk("sub_wb_data", wb_data, 32'hFFFF_FFFE);
    step();
    chk("sub_retired", retired, 32'd2);

    // SRAI x5, x6, 4
    issue(32'h40435293, 32'h8000_0000, 32'd0);
    chk("srai_exec_op", 32'(alu_opcode), 32'd5);
    chk("srai_exec_sig", 32'(alu_signal), 32'd1);
    chk("srai_exec_b", alu_b, 32'h0000_0404);
    step();
    chk("srai_wb_rd", 32'(wb_rd), 32'd5);
    chk("srai_wb_data", wb_data, 32'hF800_0000);
    step();
    chk("srai_retired", retired, 32'd3);

    // MUL is outside the supported set: writeback one cycle after accept, flagged illegal
    issue(32'h022081B3, 32'd5, 32'd7);
    chk("mul_en_n", 32'(alu_enable_n), 32'd1);
    chk("mul_wb_valid", 32'(wb_valid), 32'd1);
    chk("mul_wb_illegal", 32'(wb_illegal), 32'd1);
    chk("mul_wb_data", wb_data, 32'd0);
    chk("mul_alu_op", 32'(alu_opcode), 32'd0);
    step();
    chk("mul_retired", retired, 32'd3);
    chk("mul_idle_ready", 32'(instr_ready), 32'd1);

    // SLLI with nonzero upper bits is illegal
    issue(32'h02109193, 32'd1, 32'd0);
    chk("slli_bad_illegal", 32'(wb_illegal), 32'd1);
    step();
    chk("slli_bad_retired", retired, 32'd3);

    // ADD x0, x1, x2: legal, but data forced to zero
    issue(32'h00208033, 32'd5, 32'd7);
    step();
    chk("x0_wb_rd", 32'(wb_rd), 32'd0);
    chk("x0_wb_data", wb_data, 32'd0);
    step();
    chk("x0_retired", retired, 32'd4);

    // Backpressure: hold wb_ready low with instr_valid kept high
    wb_ready = 1'b0;
    issue(32'h002081B3, 32'd100, 32'd23);
    instr_valid = 1'b1;
    rs1_data    = 32'd1;
    rs2_data    = 32'd1;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_wb_valid", 32'(wb_valid), 32'd1);
      chk("bp_wb_data", wb_data, 32'd123);
      chk("bp_ready", 32'(instr_ready), 32'd0);
      step();
    end
    @(negedge clk);
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_after_hs_ready", 32'(instr_ready), 32'd1);
    chk("bp_after_hs_wbv", 32'(wb_valid), 32'd0);
    chk("bp_retired", retired, 32'd5);
    step();
    instr_valid = 1'b0;
    chk("bp_second_exec", 32'(alu_enable_n), 32'd0);
    chk("bp_second_a", alu_a, 32'd1);
    step();
    chk("bp_second_data", wb_data, 32'd2);
    step();
    chk("bp_second_retired", retired, 32'd6);

    // Reset in the middle of EXEC aborts the instruction
    issue(32'h002081B3, 32'd5, 32'd7);
    chk("rst_pre_exec", 32'(alu_enable_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstx_en_n", 32'(alu_enable_n), 32'd1);
    chk("rstx_ready", 32'(instr_ready), 32'd1);
    chk("rstx_alu_a", alu_a, 32'd0);
    chk("rstx_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstx_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rstx_post_wbv", 32'(wb_valid), 32'd0);
    chk("rstx_post_retired", retired, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low; ports are clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 instr_valid  input  1  upstream offers an instruction.
REQ-006 instr_ready  output  1  block can accept an instruction.
REQ-007 instr  input  32  RV32I instruction word.
REQ-008 rs1_data, rs2_data  input  XLEN each  register-file operands, sampled with instr.
REQ-009 alu_enable_n  output  1  active-low ALU enable.
REQ-010 alu_opcode  output  3  ALU op: 0 add/sub, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl/sra, 6 or, 7 and.
REQ-011 alu_signal  output  1  selects sub for op 0 and sra for op 5.
REQ-012 alu_a, alu_b  output  XLEN each  ALU operands.
REQ-013 alu_result  input  XLEN  ALU result, valid while alu_enable_n=0.
REQ-014 wb_valid, wb_ready  output/input  1 each  writeback handshake.
REQ-015 wb_rd  output  5; wb_data  output  XLEN; wb_illegal  output  1  writeback payload.
REQ-016 retired  output  32  count of completed legal instructions.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, WB; instr_ready=1 only in IDLE.
REQ-018 Accept on instr_valid&instr_ready at edge N; latch decode, rd=instr[11:7], operands.
REQ-019 Legal decode: opcode 0110011 (OP) or 0010011 (OP-IMM); all else illegal.
REQ-020 OP: alu_opcode=funct3, alu_b=rs2_data; funct7=0000000 legal for all funct3; funct7=0100000 legal only for funct3 0/5, alu_signal=1; other funct7 illegal.
REQ-021 OP-IMM: alu_b=sign-extended instr[31:20]; funct3 0 forces alu_signal=0; funct3 1 requires instr[31:25]=0; funct3 5 requires instr[31:25] in {0000000, 0100000}, alu_signal=instr[30]; other funct3 legal, signal 0.
REQ-022 alu_a=rs1_data for all legal ops.
REQ-023 Legal: IDLE->EXEC at N; in EXEC (cycle N+1) alu_enable_n=0 with latched controls; alu_result captured into wb_data at end of EXEC; EXEC->WB.
REQ-024 Illegal: IDLE->WB directly, EXEC skipped, alu_enable_n stays 1, wb_illegal=1, wb_data=0.
REQ-025 Outside EXEC: alu_enable_n=1, alu_opcode/signal/a/b=0.
REQ-026 WB: wb_valid=1, payload stable until wb_valid&wb_ready; then WB->IDLE next cycle.
REQ-027 If wb_rd=0 (legal), wb_data SHALL be 0.
REQ-028 retired increments by 1 on each WB handshake with wb_illegal=0; wraps 0xFFFFFFFF->0.
REQ-029 Latency: legal accept at N -> wb_valid from N+2; illegal -> wb_valid from N+1; max throughput one instruction per 3 cycles.
REQ-030 instr_valid while not IDLE SHALL be ignored (no accept, no state change).

Reset
REQ-031 rst_n=0 SHALL immediately: state=IDLE, instr_ready=1, alu_enable_n=1, all other outputs and latched fields 0, retired=0.
REQ-032 Reset mid-EXEC or mid-WB SHALL abort the instruction with no writeback and no retired increment.

Verification
REQ-033 ADD: instr=0x002081B3, rs1=5, rs2=7 -> EXEC op=0 sig=0 a=5 b=7; wb_rd=3, wb_data=12 at N+2, retired=1.
REQ-034 SUB: instr=0x402081B3, rs1=5, rs2=7 -> sig=1; wb_data=0xFFFFFFFE.
REQ-035 SRAI: instr=0x40435293, rs1=0x80000000 -> op=5 sig=1 b=0x00000404; wb_rd=5, wb_data=0xF8000000.
REQ-036 Illegal MUL: instr=0x022081B3 -> alu_enable_n never 0; wb_valid at N+1, wb_illegal=1, wb_data=0; retired unchanged.
REQ-037 Backpressure: wb_ready=0 for 5 cycles with instr_valid=1 -> payload stable, instr_ready=0, no second accept; accept resumes the cycle after handshake.
REQ-038 rst_n pulsed low during EXEC -> outputs per REQ-031 same cycle, no wb_valid, retired=0.
